// File: rtl/serdes_pkg.sv
// Shared types and constants for the SERDES egress path.
package serdes_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam int SKID_DEPTH = 2;

endpackage : serdes_pkg

// File: rtl/fifo_axis_skid.sv
// Two-entry head/skid buffer feeding the AXI-Stream master side of fifo_axis_reader.
// state     | meaning
// OCC_EMPTY | no word held, tvalid low
// OCC_ONE   | head holds the presented word
// OCC_TWO   | head presented, skid holds the next word
module fifo_axis_skid
    import serdes_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [DWIDTH-1:0] din,
    input  logic              pop,
    output logic [DWIDTH-1:0] tdata,
    output logic              tvalid,
    output occ_e              occ
);

    occ_e              occ_next;
    logic [DWIDTH-1:0] head_q;
    logic [DWIDTH-1:0] skid_q;
    logic              tvalid_q;
    logic              load_head;
    logic              head_from_skid;
    logic              load_skid;

    always_ff @(posedge clk) begin
        if (rst) occ <= OCC_EMPTY;
        else     occ <= occ_next;
    end

    always_comb begin
        occ_next = occ;
        case (occ)
            OCC_EMPTY: if (capture) occ_next = OCC_ONE;
            OCC_ONE: begin
                if (capture && !pop)      occ_next = OCC_TWO;
                else if (!capture && pop) occ_next = OCC_EMPTY;
            end
            OCC_TWO:   if (pop && !capture) occ_next = OCC_ONE;
            default:   occ_next = OCC_EMPTY;
        endcase
    end

    // A popping head with a full skid refills from the skid, so order is kept.
    always_comb begin
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (occ)
            OCC_EMPTY: load_head = capture;
            OCC_ONE: begin
                load_head = capture && pop;
                load_skid = capture && !pop;
            end
            OCC_TWO: begin
                load_head      = pop;
                head_from_skid = pop;
                load_skid      = capture;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            skid_q   <= '0;
            tvalid_q <= 1'b0;
        end else begin
            if (load_head) head_q <= head_from_skid ? skid_q : din;
            if (load_skid) skid_q <= din;
            tvalid_q <= (occ_next != OCC_EMPTY);
        end
    end

    assign tdata  = head_q;
    assign tvalid = tvalid_q;

    no_capture_when_full: assert property (@(posedge clk) disable iff (rst)
        !(occ == OCC_TWO && capture));

endmodule : fifo_axis_skid

// File: rtl/fifo_axis_reader.sv
// Drains a sync FIFO with 1-cycle read latency and presents it as an AXI-Stream master.
// Optional tlast generation every PKT_LEN beats when FIFO_AXIS_READER_PKT_EN is defined.
module fifo_axis_reader
    import serdes_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int PKT_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    if (PKT_LEN < 1) begin : g_pkt_len_check
        $error("PKT_LEN must be at least 1");
    end

    logic       pop;
    logic       inflight_q;
    logic [2:0] credit_used;
    occ_e       occ;

    assign pop = m_axis_tvalid & m_axis_tready;

    // Slots committed after this edge; occ >= pop whenever pop is high, so no underflow.
    assign credit_used = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en  = !fifo_empty && (credit_used < 3'(SKID_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) inflight_q <= 1'b0;
        else     inflight_q <= fifo_rd_en;
    end

    fifo_axis_skid #(
        .DWIDTH(DWIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .capture (inflight_q),
        .din     (fifo_dout),
        .pop     (pop),
        .tdata   (m_axis_tdata),
        .tvalid  (m_axis_tvalid),
        .occ     (occ)
    );

`ifdef FIFO_AXIS_READER_PKT_EN
    localparam int CW = $clog2(PKT_LEN + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

    logic [CW-1:0] beat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (pop) begin
            if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
            else                       beat_cnt <= beat_cnt + 1'b1;
        end
    end

    assign m_axis_tlast = (beat_cnt == LAST_BEAT) && m_axis_tvalid;
`else
    assign m_axis_tlast = 1'b0;
`endif

endmodule : fifo_axis_reader
